// File: rtl/vga_pkg.sv
// Shared constants and FSM state encoding for the VGA frame-fetch path.
package vga_pkg;

  localparam int unsigned H_DISP      = 640;
  localparam int unsigned V_DISP      = 480;
  localparam int unsigned FRAME_WORDS = H_DISP * V_DISP;
  localparam int unsigned PIX_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_CHECK,
    ST_REQ,
    ST_WAIT_DATA,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and a registered read port; rdata returns 0
// on flush or on a pop of an empty FIFO.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign cnt_d   = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  // Occupancy as it will be after this cycle, so space checks see same-cycle pops.
  assign count   = cnt_d;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdata    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata    <= mem_q[rd_ptr_q];
      end else if (pop) begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Frame-fetch stage: on each driver request, flush the pixel FIFO and stream
// one frame from memory in fixed bursts; the driver pops one pixel per request.
module vga_frame_reader #(
  parameter int unsigned       ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       FRAME_WORDS = vga_pkg::FRAME_WORDS,
  parameter int unsigned       BURST_LEN   = 64,
  parameter int unsigned       FIFO_DEPTH  = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read_req,
  output logic                      read_req_ack,
  input  logic                      img_data_req,
  output logic [vga_pkg::PIX_W-1:0] img_data,
  output logic                      mem_rd_req,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic                      mem_rd_ack,
  input  logic                      mem_rd_valid,
  input  logic [vga_pkg::PIX_W-1:0] mem_rd_data,
  output logic                      frame_done,
  output logic                      underflow
);

  import vga_pkg::*;

  localparam int unsigned WL_W   = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [WL_W-1:0]   FRAME_C  = WL_W'(FRAME_WORDS);
  localparam logic [WL_W-1:0]   BURST_WL = WL_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  BURST_C  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_B   = BEAT_W'(BURST_LEN - 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              pend_q, pend_d;
  logic              underflow_q, underflow_d;

  logic              flush, push;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, free_space;

  assign free_space  = DEPTH_C - fifo_count;
  assign mem_rd_addr = addr_q;
  assign underflow   = underflow_q;

  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (mem_rd_data),
    .pop   (img_data_req),
    .rdata (img_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    beat_d       = beat_q;
    pend_d       = pend_q;
    underflow_d  = underflow_q;
    flush        = 1'b0;
    push         = 1'b0;
    read_req_ack = 1'b0;
    mem_rd_req   = 1'b0;
    frame_done   = 1'b0;

    if (img_data_req && fifo_empty) underflow_d = 1'b1;

    unique case (state_q)
      // The ack only exists in ST_ACK, so IDLE needs no re-trigger guard of its own.
      ST_IDLE: if (read_req) state_d = ST_ACK;
      ST_ACK: begin
        read_req_ack = 1'b1;
        flush        = 1'b1;
        underflow_d  = 1'b0;
        pend_d       = 1'b0;
        addr_d       = BASE_ADDR;
        words_left_d = FRAME_C;
        state_d      = ST_CHECK;
      end
      ST_CHECK: begin
        if (read_req)                    state_d = ST_ACK;
        else if (words_left_q == '0)     state_d = ST_DONE;
        else if (free_space >= BURST_C)  state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_rd_req = 1'b1;
        if (read_req) pend_d = 1'b1;
        if (mem_rd_ack) begin
          beat_d  = '0;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (read_req) pend_d = 1'b1;
        if (mem_rd_valid) begin
          push   = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_B) begin
            addr_d       = addr_q + BURST_A;
            words_left_d = words_left_q - BURST_WL;
            // A burst in flight is always finished before honouring a new frame.
            state_d      = (pend_q || read_req) ? ST_ACK : ST_CHECK;
          end
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = read_req ? ST_ACK : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= BASE_ADDR;
      words_left_q <= '0;
      beat_q       <= '0;
      pend_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      beat_q       <= beat_d;
      pend_q       <= pend_d;
      underflow_q  <= underflow_d;
    end
  end

  // Returned words outside a burst window have nowhere to go and are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (state_q == ST_WAIT_DATA || !mem_rd_valid);
      assert (!(push && fifo_full));
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench: zero-wait memory model, address/pixel scoreboards, FIFO of 128.
module tb_vga_frame_reader;

  logic        clk = 1'b0;
  logic        rst, read_req, read_req_ack, img_data_req;
  logic [15:0] img_data, mem_rd_data;
  logic        mem_rd_req, mem_rd_ack, mem_rd_valid, frame_done, underflow;
  logic [7:0]  mem_rd_addr;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, bursts = 0, beat = 0, done_cnt = 0, last_beat_cyc = 0;
  int frame_id = 0, base = 0, t = 0;
  bit in_burst = 0;
  logic [7:0]  cur_addr, cur_tag;
  logic [7:0]  addr_q [$];
  logic [15:0] pix_q [$];

  vga_frame_reader #(
    .ADDR_W      (8),
    .BASE_ADDR   (8'hC0),
    .FRAME_WORDS (256),
    .BURST_LEN   (64),
    .FIFO_DEPTH  (128)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .read_req     (read_req),
    .read_req_ack (read_req_ack),
    .img_data_req (img_data_req),
    .img_data     (img_data),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ack   (mem_rd_ack),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .frame_done   (frame_done),
    .underflow    (underflow)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Frame k: bursts at C0,00,40,80 (8-bit wrap); pixel i carries tag k and its address.
  task automatic expect_frame(input int k);
    addr_q.delete();
    pix_q.delete();
    for (int b = 0; b < 4; b++) addr_q.push_back(8'(192 + b * 64));
    for (int i = 0; i < 256; i++) pix_q.push_back({8'(k), 8'(192 + i)});
  endtask

  task automatic pop_n(input int n);
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      img_data_req = 1'b1;
      tick();
      exp = (pix_q.size() != 0) ? pix_q.pop_front() : 16'hxxxx;
      check("pixel", img_data, exp);
    end
    img_data_req = 1'b0;
  endtask

  task automatic drain_frame(input int b0);
    repeat (200) tick();
    check("bp_two_bursts", bursts - b0, 2);
    check("bp_stall", mem_rd_req, 0);
    pop_n(64);
    repeat (3) tick();
    check("bp_third_burst", bursts - b0, 3);
    repeat (100) tick();
    pop_n(64);
    repeat (100) tick();
    check("all_bursts", bursts - b0, 4);
    pop_n(128);
    check("pix_drained", pix_q.size(), 0);
    check("addr_drained", addr_q.size(), 0);
  endtask

  // Zero-wait memory: acks a request in its first cycle, then streams BURST_LEN beats.
  initial begin
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rd_valid = 1'b0;
      if (!rst) begin
        if (mem_rd_ack) begin
          mem_rd_ack = 1'b0;
          beat       = 0;
          in_burst   = 1'b1;
        end
        if (in_burst) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = {cur_tag, 8'(cur_addr + beat)};
          beat++;
          if (beat == 64) begin
            in_burst      = 1'b0;
            last_beat_cyc = cyc;
          end
        end else if (mem_rd_req) begin
          check("burst_addr_expected", addr_q.size() != 0, 1);
          if (addr_q.size() != 0) check("burst_addr", mem_rd_addr, addr_q.pop_front());
          cur_addr   = mem_rd_addr;
          cur_tag    = 8'(frame_id);
          mem_rd_ack = 1'b1;
          bursts++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (frame_done) begin
        done_cnt++;
        check("done_latency", cyc - last_beat_cyc, 2);
      end
    end
  end

  initial begin
    rst = 1'b1; read_req = 1'b0; img_data_req = 1'b0;
    repeat (3) tick();
    check("rst_ack", read_req_ack, 0);
    check("rst_mem_req", mem_rd_req, 0);
    check("rst_done", frame_done, 0);
    check("rst_underflow", underflow, 0);
    check("rst_img_data", img_data, 0);
    check("rst_addr", mem_rd_addr, 8'hC0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_no_req", mem_rd_req, 0);
    end

    // Frame 1: full frame under back-pressure, addresses wrap past 8'hFF.
    frame_id = 1;
    expect_frame(1);
    base = bursts;
    read_req = 1'b1;
    tick();
    check("ack_latency", read_req_ack, 1);
    read_req = 1'b0;
    tick();
    check("ack_pulse", read_req_ack, 0);
    tick();
    check("first_req", mem_rd_req, 1);
    drain_frame(base);
    check("frame1_done", done_cnt, 1);

    // Underflow: pop on an empty FIFO.
    img_data_req = 1'b1;
    tick();
    img_data_req = 1'b0;
    check("uf_data", img_data, 0);
    check("uf_flag", underflow, 1);
    repeat (5) tick();
    check("uf_sticky", underflow, 1);

    // Frame 2: ack clears underflow, then re-request during beat 10 of burst 2.
    frame_id = 2;
    expect_frame(2);
    base = bursts;
    read_req = 1'b1;
    tick();
    check("ack2_latency", read_req_ack, 1);
    read_req = 1'b0;
    tick();
    check("uf_cleared", underflow, 0);
    t = 0;
    while (!(bursts == base + 2 && beat == 11) && t < 1000) begin
      tick();
      t++;
    end
    check("reach_b2_beat10", t < 1000, 1);
    frame_id = 3;
    expect_frame(3);
    read_req = 1'b1;
    t = 0;
    while (!read_req_ack && t < 200) begin
      tick();
      t++;
    end
    check("ack_after_b2", read_req_ack, 1);
    check("b2_complete", beat, 64);
    check("no_b3", bursts - base, 2);
    check("frame2_no_done", done_cnt, 1);
    base = bursts;
    read_req = 1'b0;
    img_data_req = 1'b1;
    tick();
    check("flush_wins_data", img_data, 0);
    check("flush_wins_uf", underflow, 0);
    tick();
    img_data_req = 1'b0;
    check("flushed_empty_data", img_data, 0);
    check("flushed_empty_uf", underflow, 1);
    check("f3_first_req", mem_rd_req, 1);

    // Frame 3 restarts at BASE_ADDR and completes normally.
    drain_frame(base);
    check("frame3_done", done_cnt, 2);
    check("uf_held", underflow, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
